ah_credit_tx: RTL and testbench
===============================

// Module: ah_credit_tx
// PURPOSE
//  Credit-based transmitter: the sending end of the credit interface of our snoopable FIFOs.
//  Takes a valid/ready stream from upstream and stages it in a small buffer.
//  Forwards each word as a one-cycle tx_valid pulse, only while a receiver credit is held.
//  Sits in front of a credit-return receiver FIFO of depth CREDITS.
// PARAMETERS
//  DATA_W     8   data width
//  CREDITS    16  initial credit count; equals receiver FIFO depth (>=1)
//  SKID_DEPTH 2   staging buffer entries (power of 2, >=2)
// PORTS
//  clk          in   1                  clock
//  rstn         in   1                  async active-low reset
//  in_data      in   DATA_W             upstream data
//  in_valid     in   1                  upstream valid
//  in_ready     out  1                  staging can accept
//  tx_data      out  DATA_W             data to receiver (registered)
//  tx_valid     out  1                  one-cycle pulse per word sent
//  tx_credit    in   1                  one-cycle pulse = one credit returned
//  credit_avail out  $clog2(CREDITS+1)  credits currently held
//  idle         out  1                  RUN, staging empty, credit_avail==CREDITS
//  err_ovf      out  1                  sticky: credit returned while already at CREDITS
//  snoop_data   in   DATA_W             snoop compare value
//  snoop_valid  in   1                  snoop request
//  snoop_match  out  1                  staged entry equals snoop_data
// BEHAVIOUR
//  Reset: rstn is asynchronous, active-low; clock is clk.
//  Reset values: in_ready=0, tx_valid=0, tx_data=0, credit_avail=0, idle=0, err_ovf=0.
//  Reset also empties staging.
//  FSM INIT->RUN:
//   INIT lasts exactly 1 cycle after rstn deasserts; it loads credit_avail=CREDITS.
//   RUN is held until reset; there are no other states.
//  Accept: in_ready = RUN && stage_count<SKID_DEPTH, with no pop look-ahead.
//   A word is enqueued on an edge where in_valid && in_ready.
//  Send: on an edge where staging is non-empty && credit_avail>0, the head is popped:
//   tx_data<=head, tx_valid<=1, credit_avail decrements. Otherwise tx_valid<=0 and tx_data holds.
//  Latency: a word accepted at edge E0 into an empty stage, with credit>0, gives tx_valid high after E1.
//   Back-to-back sends are allowed: 1 word/cycle sustained.
//  Order: strict FIFO; head pointer and tail pointer wrap modulo SKID_DEPTH.
//  Credits:
//   send + tx_credit on the same edge -> count unchanged.
//   tx_credit alone -> +1.
//   tx_credit at CREDITS with no send -> count saturates at CREDITS and err_ovf<=1 (sticky until reset).
//  credit_avail==0: staged data waits; in_ready still follows stage occupancy.
//  Enqueue and pop on the same edge are both legal; occupancy is unchanged.
//  Reset mid-operation drops staged data and in-flight credits. The receiver must be reset in the same window.
// CONFIGURATION
//  AH_CREDIT_TX_SNOOP_EN defined:
//   snoop_match = snoop_valid && any occupied staging entry == snoop_data.
//   The compare is combinational with the same-cycle result; unoccupied entries never match.
//  AH_CREDIT_TX_SNOOP_EN undefined:
//   snoop ports remain present; snoop_match is tied 0 and no compare logic is built.
// STRUCTURE
//  Package ah_credit_pkg:
//   FSM state enum {ST_INIT, ST_RUN}
//   credit width function/localparam
//  Sub-module ah_credit_tx_stage: SKID_DEPTH staging FIFO with per-entry occupancy.
//   Exposes head, count and entry vector for the snoop compare.
//  Top: FSM, credit counter, err flag, tx register, snoop OR-reduce.
// TESTING (DATA_W=8, CREDITS=16, SKID_DEPTH=2)
//  1 Reset release -> credit_avail=16 one cycle after INIT; idle=1; tx_valid=0.
//  2 Stream 0x01..0x14 with no credit returns -> tx pulses 0x01..0x10, then credit_avail=0.
//    Stage fills with 0x11,0x12; in_ready=0.
//  3 From state 2, return 1 credit -> exactly one tx_valid with 0x11; credit_avail stays 0; in_ready=1.
//  4 Credit return on the same edge as a send -> credit_avail unchanged.
//    17th return at full credits -> credit_avail=16 and err_ovf=1 until rstn.
//  5 SNOOP_EN with stage holding 0xA5: snoop 0xA5 -> match=1; snoop 0x5A -> 0.
//    After 0xA5 is sent, snoop 0xA5 -> 0. Without the macro, match is always 0.
//  6 Assert rstn low while the stage is full and credits are partly used -> all outputs reach reset values.
//    On release, credit_avail=16 and no stale tx_valid.

Source files
------------

// File: rtl/ah_credit_tx_pkg.sv
// ---------------------------------------------------------------------------
// ah_credit_pkg
// Shared types and helpers for the ah_credit_tx block.
//   state_e  : FSM state of the transmitter (ST_INIT, ST_RUN)
//   credit_w : width needed to hold a credit count of 0..credits
// ---------------------------------------------------------------------------
package ah_credit_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int credit_w(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/ah_credit_tx_if.sv
// ---------------------------------------------------------------------------
// ah_credit_tx_if
// Groups the upstream valid/ready stream and the downstream credit link.
//   in_data/in_valid/in_ready : upstream stream. A word moves on a clock edge
//                               where in_valid && in_ready are both high;
//                               in_valid may be raised regardless of in_ready.
//   tx_data/tx_valid          : one-cycle pulse per word sent to the receiver
//   tx_credit                 : one-cycle pulse per credit returned
// Modports:
//   master : the credit transmitter (drives in_ready and the tx side)
//   slave  : the environment (upstream source plus credit-return receiver)
// ---------------------------------------------------------------------------
interface ah_credit_tx_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_credit;

    modport master (
        input  in_data, in_valid, tx_credit,
        output in_ready, tx_data, tx_valid
    );

    modport slave (
        output in_data, in_valid, tx_credit,
        input  in_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/ah_credit_tx_stage.sv
// ---------------------------------------------------------------------------
// ah_credit_tx_stage
// Small staging FIFO with per-entry occupancy bits, DEPTH entries (power of 2).
// The caller guarantees push only when count < DEPTH and pop only when
// count > 0; pointers wrap naturally because DEPTH is a power of two.
// Ports:
//   clk, rstn     : clock, async active-low reset (empties the FIFO)
//   push_i        : enqueue push_data_i this edge
//   push_data_i   : data to enqueue
//   pop_i         : drop the head entry this edge
//   head_o        : current head entry
//   count_o       : number of occupied entries
//   entries_o     : all storage entries (for snoop compare)
//   occ_o         : per-entry occupancy
// ---------------------------------------------------------------------------
module ah_credit_tx_stage #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          push_i,
    input  logic [DATA_W-1:0]             push_data_i,
    input  logic                          pop_i,
    output logic [DATA_W-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic [DEPTH-1:0][DATA_W-1:0]  entries_o,
    output logic [DEPTH-1:0]              occ_o
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0]             occ_q;
    logic [PW-1:0]                wr_q;
    logic [PW-1:0]                rd_q;
    logic [CNTW-1:0]              count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q   <= '0;
            occ_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            // Push and pop never target the same slot: push needs a free
            // slot and pop needs an occupied one.
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                occ_q[wr_q] <= 1'b1;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop_i) begin
                occ_q[rd_q] <= 1'b0;
                rd_q        <= rd_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o    = mem_q[rd_q];
    assign count_o   = count_q;
    assign entries_o = mem_q;
    assign occ_o     = occ_q;

endmodule

// File: rtl/ah_credit_tx.sv
// ---------------------------------------------------------------------------
// ah_credit_tx
// Credit-based transmitter. Stages upstream words in a small FIFO and sends
// each as a one-cycle tx_valid pulse only while a receiver credit is held.
// Optional feature macro: AH_CREDIT_TX_SNOOP_EN (staged-entry snoop compare).
// Ports:
//   clk, rstn     : clock, async active-low reset
//   bus           : ah_credit_tx_if.master (in_* stream, tx_* and tx_credit)
//   credit_avail  : credits currently held
//   idle          : RUN, staging empty and all credits held
//   err_ovf       : sticky, credit returned while already holding CREDITS
//   snoop_data    : snoop compare value
//   snoop_valid   : snoop request
//   snoop_match   : some occupied staged entry equals snoop_data
//   dbg_state     : current FSM state
// ---------------------------------------------------------------------------
module ah_credit_tx
    import ah_credit_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CREDITS    = 16,
    parameter int SKID_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rstn,
    ah_credit_tx_if.master                 bus,
    output logic [credit_w(CREDITS)-1:0]   credit_avail,
    output logic                           idle,
    output logic                           err_ovf,
    input  logic [DATA_W-1:0]              snoop_data,
    input  logic                           snoop_valid,
    output logic                           snoop_match,
    output state_e                         dbg_state
);
    localparam int CW   = credit_w(CREDITS);
    localparam int CNTW = $clog2(SKID_DEPTH + 1);
    localparam logic [CW-1:0]   CRED_MAX = CW'(CREDITS);
    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(SKID_DEPTH);

    state_e                            state_q;
    logic [CW-1:0]                     cred_q, cred_d;
    logic                              err_q, err_d;
    logic                              tx_valid_q;
    logic [DATA_W-1:0]                 tx_data_q;

    logic [DATA_W-1:0]                 stage_head;
    logic [CNTW-1:0]                   stage_count;
    logic [SKID_DEPTH-1:0][DATA_W-1:0] stage_entries;
    logic [SKID_DEPTH-1:0]             stage_occ;

    logic run, accept, send;

    assign run          = (state_q == ST_RUN);
    // No pop look-ahead: a full stage refuses input even on a send edge.
    assign bus.in_ready = run && (stage_count < CNT_MAX);
    assign accept       = bus.in_valid && bus.in_ready;
    assign send         = run && (stage_count != '0) && (cred_q != '0);

    ah_credit_tx_stage #(
        .DATA_W (DATA_W),
        .DEPTH  (SKID_DEPTH)
    ) u_stage (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (accept),
        .push_data_i (bus.in_data),
        .pop_i       (send),
        .head_o      (stage_head),
        .count_o     (stage_count),
        .entries_o   (stage_entries),
        .occ_o       (stage_occ)
    );

    // Credit bookkeeping in RUN: a send and a return on the same edge cancel;
    // a return while already full saturates and raises the sticky error.
    always_comb begin
        cred_d = cred_q;
        err_d  = err_q;
        case ({send, bus.tx_credit})
            2'b10: cred_d = cred_q - CW'(1);
            2'b01: begin
                if (cred_q == CRED_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cred_d = cred_q + CW'(1);
                end
            end
            default: cred_d = cred_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_INIT;
            cred_q     <= '0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    state_q <= ST_RUN;
                    cred_q  <= CRED_MAX;
                end
                ST_RUN: begin
                    cred_q <= cred_d;
                    err_q  <= err_d;
                end
                default: state_q <= ST_INIT;
            endcase
            tx_valid_q <= send;
            if (send) begin
                tx_data_q <= stage_head;
            end
        end
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign credit_avail = cred_q;
    assign err_ovf      = err_q;
    assign idle         = run && (stage_count == '0) && (cred_q == CRED_MAX);
    assign dbg_state    = state_q;

`ifdef AH_CREDIT_TX_SNOOP_EN
    // Same-cycle compare against every occupied entry; free slots never match.
    logic any_hit;
    always_comb begin
        any_hit = 1'b0;
        for (int i = 0; i < SKID_DEPTH; i++) begin
            if (stage_occ[i] && (stage_entries[i] == snoop_data)) begin
                any_hit = 1'b1;
            end
        end
    end
    assign snoop_match = snoop_valid && any_hit;
`else
    // Snoop ports stay for a stable footprint; nothing is compared.
    logic unused_snoop;
    assign unused_snoop = ^{snoop_data, snoop_valid, stage_entries, stage_occ};
    assign snoop_match  = 1'b0;
`endif

endmodule

// File: tb/tb_ah_credit_tx.sv
module tb_ah_credit_tx;
    import ah_credit_pkg::*;

    localparam int DW   = 8;
    localparam int CRED = 16;
    localparam int SD   = 2;
    localparam int CW   = $clog2(CRED + 1);

    // clock / reset
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ah_credit_tx_if #(.DATA_W(DW)) bus ();

    logic [CW-1:0] credit_avail;
    logic          idle;
    logic          err_ovf;
    logic [DW-1:0] snoop_data;
    logic          snoop_valid;
    logic          snoop_match;
    state_e        dbg_state;

    ah_credit_tx #(
        .DATA_W     (DW),
        .CREDITS    (CRED),
        .SKID_DEPTH (SD)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus),
        .credit_avail (credit_avail),
        .idle         (idle),
        .err_ovf      (err_ovf),
        .snoop_data   (snoop_data),
        .snoop_valid  (snoop_valid),
        .snoop_match  (snoop_match),
        .dbg_state    (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // reference model: staged words, credits held, error flag, last tx word
    logic [DW-1:0] exp_q[$];
    int            m_cred;
    bit            m_run;
    bit            m_err;
    logic [DW-1:0] m_tx_data;
    logic [DW-1:0] rx_q[$];   // words observed on tx
    bit            last_acc;

    task automatic reset_model();
        exp_q.delete();
        m_cred    = 0;
        m_run     = 0;
        m_err     = 0;
        m_tx_data = '0;
    endtask

    // drive one clock cycle; checks comb outputs mid-cycle, registered after edge
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit cr);
        bit rdy, push, pop, exp_idle, exp_match;
        logic [DW-1:0] head;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.tx_credit = cr;
        head = '0;
        @(negedge clk);
        rdy      = m_run && (exp_q.size() < SD);
        exp_idle = m_run && (exp_q.size() == 0) && (m_cred == CRED);
        exp_match = 1'b0;
`ifdef AH_CREDIT_TX_SNOOP_EN
        if (snoop_valid) foreach (exp_q[i]) if (exp_q[i] == snoop_data) exp_match = 1'b1;
`endif
        checks++;
        if (bus.in_ready !== rdy) begin
            errors++; $display("FAIL in_ready got %b exp %b t=%0t", bus.in_ready, rdy, $time);
        end
        checks++;
        if (idle !== exp_idle) begin
            errors++; $display("FAIL idle got %b exp %b t=%0t", idle, exp_idle, $time);
        end
        checks++;
        if (snoop_match !== exp_match) begin
            errors++; $display("FAIL snoop_match got %b exp %b t=%0t", snoop_match, exp_match, $time);
        end
        push = v && rdy;
        pop  = m_run && (exp_q.size() > 0) && (m_cred > 0);
        if (pop) head = exp_q.pop_front();
        if (!m_run) begin
            m_run  = 1;
            m_cred = CRED;
        end else if (pop && !cr) begin
            m_cred--;
        end else if (cr && !pop) begin
            if (m_cred == CRED) m_err = 1;
            else m_cred++;
        end
        if (pop) m_tx_data = head;
        if (push) exp_q.push_back(d);
        last_acc = push;
        @(posedge clk);
        #1;
        checks++;
        if (bus.tx_valid !== pop) begin
            errors++; $display("FAIL tx_valid got %b exp %b t=%0t", bus.tx_valid, pop, $time);
        end
        checks++;
        if (bus.tx_data !== m_tx_data) begin
            errors++; $display("FAIL tx_data got %h exp %h t=%0t", bus.tx_data, m_tx_data, $time);
        end
        checks++;
        if (credit_avail !== CW'(m_cred)) begin
            errors++; $display("FAIL credit_avail got %0d exp %0d t=%0t", credit_avail, m_cred, $time);
        end
        checks++;
        if (err_ovf !== m_err) begin
            errors++; $display("FAIL err_ovf got %b exp %b t=%0t", err_ovf, m_err, $time);
        end
        if (bus.tx_valid === 1'b1) rx_q.push_back(bus.tx_data);
    endtask

    // asserts reset away from the edge and checks outputs asynchronously
    task automatic apply_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.tx_credit = 1'b0;
        snoop_valid   = 1'b0;
        snoop_data    = '0;
        rstn = 1'b0;
        #2;
        reset_model();
        checks++;
        if ({bus.in_ready, bus.tx_valid, idle, err_ovf} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got rdy=%b txv=%b idle=%b err=%b exp 0000",
                               bus.in_ready, bus.tx_valid, idle, err_ovf);
        end
        checks++;
        if (bus.tx_data !== 8'h00 || credit_avail !== '0) begin
            errors++; $display("FAIL reset_values got tx_data=%h credit=%0d exp 00/0", bus.tx_data, credit_avail);
        end
        checks++;
        if (dbg_state !== ST_INIT) begin
            errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_INIT);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        cycle(0, '0, 0);   // INIT edge loads credits
        checks++;
        if (credit_avail !== CW'(16)) begin
            errors++; $display("FAIL init_credit got %0d exp 16", credit_avail);
        end
        cycle(0, '0, 0);
        checks++;
        if (idle !== 1'b1 || bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL init_idle got idle=%b txv=%b exp 1/0", idle, bus.tx_valid);
        end
    endtask

    task automatic test_stream();
        int nxt = 1;
        rx_q.delete();
        for (int c = 0; c < 40 && nxt <= 20; c++) begin
            cycle(1, DW'(nxt), 0);
            if (last_acc) nxt++;
        end
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        checks++;
        if (rx_q.size() != 16) begin
            errors++; $display("FAIL stream_count got %0d exp 16", rx_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (rx_q[i] !== DW'(i + 1)) begin
                    errors++; $display("FAIL stream_word%0d got %h exp %h", i, rx_q[i], DW'(i + 1));
                end
            end
        end
        checks++;
        if (credit_avail !== '0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL stream_stall got credit=%0d rdy=%b exp 0/0", credit_avail, bus.in_ready);
        end
    endtask

    task automatic test_one_credit();
        rx_q.delete();
        cycle(0, '0, 1);
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h11) begin
            errors++; $display("FAIL one_credit got n=%0d w=%h exp n=1 w=11", rx_q.size(),
                               (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
        checks++;
        if (credit_avail !== '0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL one_credit_state got credit=%0d rdy=%b exp 0/1", credit_avail, bus.in_ready);
        end
    endtask

    task automatic test_credit_ovf();
        cycle(0, '0, 1);            // credit -> 1
        cycle(0, '0, 1);            // send 0x12 with return: unchanged
        checks++;
        if (credit_avail !== CW'(1) || bus.tx_data !== 8'h12) begin
            errors++; $display("FAIL same_edge got credit=%0d data=%h exp 1/12", credit_avail, bus.tx_data);
        end
        repeat (15) cycle(0, '0, 1);
        cycle(1, 8'h77, 0);
        cycle(0, '0, 1);            // send at full credits with a return
        checks++;
        if (credit_avail !== CW'(16) || bus.tx_valid !== 1'b1 || err_ovf !== 1'b0) begin
            errors++; $display("FAIL full_same_edge got credit=%0d txv=%b err=%b exp 16/1/0",
                               credit_avail, bus.tx_valid, err_ovf);
        end
        cycle(0, '0, 1);            // 17th return
        repeat (3) cycle(0, '0, 0);
        checks++;
        if (credit_avail !== CW'(16) || err_ovf !== 1'b1) begin
            errors++; $display("FAIL ovf got credit=%0d err=%b exp 16/1", credit_avail, err_ovf);
        end
    endtask

    task automatic test_snoop();
        apply_reset();
        cycle(0, '0, 0);
        cycle(1, 8'hA5, 0);
        snoop_valid = 1'b1; snoop_data = 8'hA5;
        cycle(0, '0, 0);            // 0xA5 staged: match when enabled
        cycle(0, '0, 0);            // already sent: no match
        snoop_data = 8'h5A;
        cycle(1, 8'hA5, 0);
        cycle(0, '0, 0);            // 0xA5 staged, snoop 0x5A: no match
        snoop_valid = 1'b0;
        cycle(0, '0, 0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bit cr;
            int phase = (c / 50) % 3;   // vary return rate
            cr = ((CRED - m_cred) > 0) && ($urandom_range(0, phase + 1) == 0);
            snoop_valid = $urandom_range(0, 1);
            if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) snoop_data = exp_q[0];
            else snoop_data = DW'($urandom_range(0, 255));
            cycle($urandom_range(0, 3) != 0, DW'($urandom_range(0, 255)), cr);
        end
        snoop_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 30; c++) cycle(1, DW'($urandom_range(0, 255)), 0);
        apply_reset();
        cycle(0, '0, 0);
        checks++;
        if (credit_avail !== CW'(16)) begin
            errors++; $display("FAIL mid_reset_credit got %0d exp 16", credit_avail);
        end
        repeat (3) cycle(0, '0, 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.tx_credit = 1'b0;
        snoop_valid   = 1'b0;
        snoop_data    = '0;
        reset_model();
        test_reset();
        test_stream();
        test_one_credit();
        test_credit_ovf();
        test_snoop();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
